// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch and data ports with a per-access timeout.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed data-over-fetch.
module ucsbece154b_mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} stateT;

  stateT             state, stateNext;
  logic [7:0]        waitCnt, waitCntNext, waitInc;
  logic              grantData;
  logic              memReqNext, memWeNext, ifReadyNext, dReadyNext, errNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext, ifRdataNext, dRdataNext;
`ifdef MEM_ARB_RR_EN
  logic              lastGrantData, lastGrantDataNext;
`endif

  assign waitInc = waitCnt + 8'd1;

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On contention the port that was not granted last time wins.
    grantData = d_req_i && (!if_req_i || !lastGrantData);
`else
    grantData = d_req_i;
`endif
  end

  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    memReqNext   = mem_req_o;
    memWeNext    = mem_we_o;
    memAddrNext  = mem_addr_o;
    memWdataNext = mem_wdata_o;
    ifRdataNext  = if_rdata_o;
    dRdataNext   = d_rdata_o;
    ifReadyNext  = 1'b0;
    dReadyNext   = 1'b0;
    errNext      = 1'b0;
`ifdef MEM_ARB_RR_EN
    lastGrantDataNext = lastGrantData;
`endif
    case (state)
      StIdle: begin
        waitCntNext = '0;
        if (grantData) begin
          stateNext    = StData;
          memReqNext   = 1'b1;
          memWeNext    = d_we_i;
          memAddrNext  = d_addr_i;
          memWdataNext = d_wdata_i;
`ifdef MEM_ARB_RR_EN
          lastGrantDataNext = 1'b1;
`endif
        end else if (if_req_i) begin
          stateNext   = StFetch;
          memReqNext  = 1'b1;
          memWeNext   = 1'b0;
          memAddrNext = if_addr_i;
`ifdef MEM_ARB_RR_EN
          lastGrantDataNext = 1'b0;
`endif
        end
      end
      StFetch, StData: begin
        // An ack in the cycle the counter would hit the limit still completes normally.
        if (mem_ack_i || waitInc == 8'(WAIT_MAX)) begin
          stateNext   = StIdle;
          memReqNext  = 1'b0;
          memWeNext   = 1'b0;
          waitCntNext = '0;
          errNext     = !mem_ack_i;
          if (state == StFetch) begin
            ifReadyNext = 1'b1;
            ifRdataNext = mem_ack_i ? mem_rdata_i : '0;
          end else begin
            dReadyNext = 1'b1;
            if (!mem_ack_i) begin
              dRdataNext = '0;
            end else if (!mem_we_o) begin
              dRdataNext = mem_rdata_i;
            end
          end
        end else begin
          waitCntNext = waitInc;
        end
      end
      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      waitCnt     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      if_ready_o  <= 1'b0;
      d_ready_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= stateNext;
      waitCnt     <= waitCntNext;
      mem_req_o   <= memReqNext;
      mem_we_o    <= memWeNext;
      mem_addr_o  <= memAddrNext;
      mem_wdata_o <= memWdataNext;
      if_rdata_o  <= ifRdataNext;
      d_rdata_o   <= dRdataNext;
      if_ready_o  <= ifReadyNext;
      d_ready_o   <= dReadyNext;
      err_o       <= errNext;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrantData <= 1'b0;
    end else begin
      lastGrantData <= lastGrantDataNext;
    end
  end
`endif

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Scoreboard bench for ucsbece154b_mem_arbiter: directed corner cases, then random fetch/data
// traffic against a behavioural memory whose latency is encoded in address bits [6:4].
module tb_ucsbece154b_mem_arbiter;
  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ready_o, d_ready_o, mem_req_o, mem_we_o, err_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  ucsbece154b_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] rdata; logic err;} expT;
  expT         ifQ[$], dQ[$];
  int          nChecks = 0, nPass = 0;
  int          forceDelay = -1;
  logic [31:0] refMem[logic [31:0]];
  logic [31:0] memArr[logic [31:0]];
  logic [31:0] dLast = '0, ifHold = '0, dHold = '0;

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  // Cycles the memory withholds ack before acking; >= WAIT_MAX means it never acks.
  function automatic int effDelay(input logic [31:0] a);
    return (forceDelay >= 0) ? forceDelay : int'(a[6:4]);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Requester tasks are entered 2 time units after a rising edge and return likewise.
  task automatic doFetch(input logic [31:0] addr, output int lat);
    expT e;
    e.err   = effDelay(addr) >= WAIT_MAX;
    e.rdata = e.err ? 32'h0 : refRead(addr);
    ifQ.push_back(e);
    if_req_i  = 1'b1;
    if_addr_i = addr;
    lat = 0;
    do begin @(posedge clk); #2; lat++; end while (!if_ready_o && lat < 60);
    if (!if_ready_o) begin
      nChecks++;
      $display("FAIL if_wait: no if_ready_o after %0d cycles, required within 60", lat);
    end
    if_req_i = 1'b0;
  endtask

  task automatic doData(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat);
    expT e;
    e.err = effDelay(addr) >= WAIT_MAX;
    if (e.err) e.rdata = 32'h0;
    else if (we) e.rdata = dLast;
    else e.rdata = refRead(addr);
    if (we && !e.err) refMem[addr] = wd;
    dLast = e.rdata;
    dQ.push_back(e);
    d_req_i   = 1'b1;
    d_we_i    = we;
    d_addr_i  = addr;
    d_wdata_i = wd;
    lat = 0;
    do begin @(posedge clk); #2; lat++; end while (!d_ready_o && lat < 60);
    if (!d_ready_o) begin
      nChecks++;
      $display("FAIL d_wait: no d_ready_o after %0d cycles, required within 60", lat);
    end
    d_req_i = 1'b0;
  endtask

  // Memory responder: checks grant choice and request stability, acks after the encoded delay,
  // and throws spurious acks while no request is outstanding.
  int          acc = 0, curDelay = 0;
  logic        lastWasData = 1'b0, isData, expData, curWe;
  logic [31:0] curAddr, curWd;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        acc = 0;
        lastWasData = 1'b0;
        mem_ack_i = 1'b0;
      end else if (mem_req_o) begin
        if (acc == 0) begin
          isData = d_req_i && (mem_addr_o == d_addr_i);
`ifdef MEM_ARB_RR_EN
          expData = (if_req_i && d_req_i) ? !lastWasData : d_req_i;
`else
          expData = d_req_i;
`endif
          chk("grant_is_data", isData, expData);
          chk("grant_addr", mem_addr_o, isData ? d_addr_i : if_addr_i);
          chk("grant_we", mem_we_o, isData ? d_we_i : 1'b0);
          if (isData && d_we_i) chk("grant_wdata", mem_wdata_o, d_wdata_i);
          lastWasData = isData;
          curAddr = mem_addr_o;
          curWe = mem_we_o;
          curWd = mem_wdata_o;
          curDelay = effDelay(mem_addr_o);
        end else begin
          chk("hold_addr", mem_addr_o, curAddr);
          chk("hold_we", mem_we_o, curWe);
          chk("hold_wdata", mem_wdata_o, curWd);
        end
        acc++;
        if (acc > WAIT_MAX) begin
          nChecks++;
          $display("FAIL req_limit: mem_req_o high %0d cycles, required at most %0d", acc, WAIT_MAX);
        end
        if (acc == curDelay + 1) begin
          mem_ack_i = 1'b1;
          if (curWe) begin
            mem_rdata_i = $urandom;
            memArr[curAddr] = curWd;
          end else begin
            mem_rdata_i = memArr.exists(curAddr) ? memArr[curAddr] : initWord(curAddr);
          end
        end else begin
          mem_ack_i = 1'b0;
          mem_rdata_i = $urandom;
        end
      end else begin
        acc = 0;
        mem_ack_i = ($urandom_range(0, 3) == 0);
        mem_rdata_i = $urandom;
      end
    end
  end

  // Monitor: pops the expected response whenever a ready pulse appears.
  expT eIf, eD;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        ifHold = '0;
        dHold = '0;
      end else begin
        if (if_ready_o) begin
          if (ifQ.size() == 0) begin
            nChecks++;
            $display("FAIL if_extra: if_ready_o=1 with no fetch outstanding, required 0");
          end else begin
            eIf = ifQ.pop_front();
            chk("if_rdata", if_rdata_o, eIf.rdata);
            chk("if_err", err_o, eIf.err);
            ifHold = eIf.rdata;
          end
        end else chk("if_rdata_hold", if_rdata_o, ifHold);
        if (d_ready_o) begin
          if (dQ.size() == 0) begin
            nChecks++;
            $display("FAIL d_extra: d_ready_o=1 with no data access outstanding, required 0");
          end else begin
            eD = dQ.pop_front();
            chk("d_rdata", d_rdata_o, eD.rdata);
            chk("d_err", err_o, eD.err);
            dHold = eD.rdata;
          end
        end else chk("d_rdata_hold", d_rdata_o, dHold);
        if (!if_ready_o && !d_ready_o) chk("err_without_ready", err_o, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  int lat, lat2;
  initial begin
    refMem[32'h100] = 32'hDEADBEEF;
    memArr[32'h100] = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_ready", {if_ready_o, d_ready_o, err_o}, 3'b000);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
    #1 reset = 1'b0;
    @(posedge clk); #2;

    doFetch(32'h100, lat);
    chk("fetch_latency", lat, 2);

    fork
      doFetch(32'h104, lat);
      doData(1'b0, 32'h2000, 32'h0, lat2);
    join
    chk("pair1_fetch_lat", lat, 4);
    chk("pair1_data_lat", lat2, 2);

    doData(1'b0, 32'h2004, 32'h0, lat2);
    fork
      doFetch(32'h108, lat);
      doData(1'b0, 32'h2008, 32'h0, lat2);
    join
`ifdef MEM_ARB_RR_EN
    chk("pair2_fetch_lat", lat, 2);
    chk("pair2_data_lat", lat2, 4);
`else
    chk("pair2_fetch_lat", lat, 4);
    chk("pair2_data_lat", lat2, 2);
`endif

    forceDelay = 2;
    doData(1'b1, 32'h40, 32'h12345678, lat);
    chk("store_latency", lat, 4);
    forceDelay = WAIT_MAX + 3;
    doData(1'b0, 32'h2010, 32'h0, lat);
    chk("load_timeout_latency", lat, WAIT_MAX + 1);
    forceDelay = WAIT_MAX - 1;
    doData(1'b0, 32'h2020, 32'h0, lat);
    chk("ack_at_limit_latency", lat, WAIT_MAX + 1);
    forceDelay = WAIT_MAX;
    doFetch(32'h1100, lat);
    chk("fetch_timeout_latency", lat, WAIT_MAX + 1);

    forceDelay = WAIT_MAX + 3;
    if_req_i = 1'b1;
    if_addr_i = 32'h300;
    @(posedge clk); #2;
    @(posedge clk); #3;
    chk("pre_reset_req", mem_req_o, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req_o, 1'b0);
    chk("midrst_mem_we", mem_we_o, 1'b0);
    chk("midrst_ready", {if_ready_o, d_ready_o, err_o}, 3'b000);
    chk("midrst_addr_data", {mem_addr_o, mem_wdata_o}, 64'h0);
    chk("midrst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
    if_req_i = 1'b0;
    forceDelay = -1;
    dLast = '0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    doFetch(32'h0, lat);
    chk("post_reset_fetch_lat", lat, 2);

    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        doFetch(32'h1000 + (32'($urandom_range(0, 255)) << 2), lat);
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        doData(1'($urandom_range(0, 1)), 32'h2000 + (32'($urandom_range(0, 63)) << 2),
               $urandom, lat2);
      end
    join

    repeat (5) @(posedge clk);
    #1;
    chk("if_queue_drained", ifQ.size(), 0);
    chk("d_queue_drained", dQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
